// File: rtl/sram_arb2.sv
// Two-client read/write arbiter for the sram_4k_64b simple dual-port macro.
// Optional same-cycle write-to-read forwarding is enabled with `define SRAM_ARB_FWD_EN.
module sram_arb2 #(
  parameter int AW = 12,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c0_req_valid,
  output logic          c0_req_ready,
  input  logic          c0_req_we,
  input  logic [AW-1:0] c0_req_addr,
  input  logic [DW-1:0] c0_req_wdata,
  output logic          c0_rsp_valid,
  output logic [DW-1:0] c0_rsp_rdata,
  input  logic          c1_req_valid,
  output logic          c1_req_ready,
  input  logic          c1_req_we,
  input  logic [AW-1:0] c1_req_addr,
  input  logic [DW-1:0] c1_req_wdata,
  output logic          c1_rsp_valid,
  output logic [DW-1:0] c1_rsp_rdata,
  output logic          sram_wsbn,
  output logic [AW-1:0] sram_waddr,
  output logic [DW-1:0] sram_wdata,
  output logic          sram_csbn,
  output logic [AW-1:0] sram_raddr,
  input  logic [DW-1:0] sram_rdata
);

  logic          rd_prio;
  logic          wr_prio;
  logic          rd_pend;
  logic          rd_owner;
  logic          c0_rd, c1_rd, c0_wr, c1_wr;
  logic          rd_gnt0, rd_gnt1, wr_gnt0, wr_gnt1;
  logic          rd_any, wr_any;
  logic [DW-1:0] rsp_data;

  assign c0_rd = c0_req_valid & ~c0_req_we;
  assign c1_rd = c1_req_valid & ~c1_req_we;
  assign c0_wr = c0_req_valid &  c0_req_we;
  assign c1_wr = c1_req_valid &  c1_req_we;

  // Grants are suppressed while rst is high so nothing transfers during reset.
  assign rd_gnt0 = ~rst & c0_rd & (~c1_rd | ~rd_prio);
  assign rd_gnt1 = ~rst & c1_rd & (~c0_rd |  rd_prio);
  assign wr_gnt0 = ~rst & c0_wr & (~c1_wr | ~wr_prio);
  assign wr_gnt1 = ~rst & c1_wr & (~c0_wr |  wr_prio);

  assign rd_any = rd_gnt0 | rd_gnt1;
  assign wr_any = wr_gnt0 | wr_gnt1;

  assign c0_req_ready = rd_gnt0 | wr_gnt0;
  assign c1_req_ready = rd_gnt1 | wr_gnt1;

  // csbn also gates writes inside the macro, so it drops on write-only cycles too.
  assign sram_wsbn  = ~wr_any;
  assign sram_csbn  = ~(rd_any | wr_any);
  assign sram_raddr = rd_gnt1 ? c1_req_addr  : c0_req_addr;
  assign sram_waddr = wr_gnt1 ? c1_req_addr  : c0_req_addr;
  assign sram_wdata = wr_gnt1 ? c1_req_wdata : c0_req_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_prio  <= 1'b0;
      wr_prio  <= 1'b0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      if (rd_gnt0)      rd_prio <= 1'b1;
      else if (rd_gnt1) rd_prio <= 1'b0;
      if (wr_gnt0)      wr_prio <= 1'b1;
      else if (wr_gnt1) wr_prio <= 1'b0;
      rd_pend <= rd_any;
      if (rd_any) rd_owner <= rd_gnt1;
    end
  end

`ifdef SRAM_ARB_FWD_EN
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_hit <= 1'b0;
    end else begin
      fwd_hit <= rd_any & wr_any & (sram_raddr == sram_waddr);
      if (rd_any & wr_any & (sram_raddr == sram_waddr)) fwd_data <= sram_wdata;
    end
  end

  assign rsp_data = fwd_hit ? fwd_data : sram_rdata;
`else
  assign rsp_data = sram_rdata;
`endif

  assign c0_rsp_valid = rd_pend & ~rd_owner;
  assign c1_rsp_valid = rd_pend &  rd_owner;
  assign c0_rsp_rdata = rsp_data;
  assign c1_rsp_rdata = rsp_data;

endmodule

// File: doc/sram_arb2.md
# sram_arb2

Two-client arbiter and sequencer for the 4096 x 64-bit simple dual-port SRAM macro (`sram_4k_64b`). It sits between the SRAM and two independent masters: client 0, the DMA/loader, and client 1, the compute engine. Per cycle it grants at most one read and one write, drives the macro's active-low enables, and returns read data with a qualified valid one cycle after the grant. Contention for the same port is resolved round-robin, with an independent pointer per port.

## Interface
Parameters:
- `AW`, 12: address width (4096 words)
- `DW`, 64: data width

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous reset, active high
- `c0_req_valid` / `c1_req_valid`  in  1  request present
- `c0_req_ready` / `c1_req_ready`  out  1  request granted this cycle
- `c0_req_we` / `c1_req_we`  in  1  1 = write, 0 = read
- `c0_req_addr` / `c1_req_addr`  in  AW  word address
- `c0_req_wdata` / `c1_req_wdata`  in  DW  write data
- `c0_rsp_valid` / `c1_rsp_valid`  out  1  read data valid for that client
- `c0_rsp_rdata` / `c1_rsp_rdata`  out  DW  read data; meaningful only while the matching rsp_valid is high
- `sram_wsbn`  out  1  SRAM write enable, active low
- `sram_waddr`  out  AW  SRAM write address
- `sram_wdata`  out  DW  SRAM write data
- `sram_csbn`  out  1  SRAM chip/read enable, active low
- `sram_raddr`  out  AW  SRAM read address
- `sram_rdata`  in  DW  SRAM registered read data

## Operation
- Requests are classed per cycle as read (`we=0`) or write (`we=1`). The read port and write port are arbitrated independently.
- Per-port arbitration:
  - One requester: it is granted.
  - Both requesters: the client named by `rd_prio` (read port) or `wr_prio` (write port) is granted.
  - After any grant, that port's pointer moves to the client that was not granted.
  - With no grant, the pointer holds.
- Handshake: `cN_req_ready` is combinational from the current valids, `we` bits and pointers. A transfer occurs when valid && ready. A client that is not granted must hold its request stable.
- SRAM drive:
  - `sram_wsbn = ~write_grant`.
  - `sram_csbn = ~(read_grant | write_grant)`. The macro only writes while csbn is low, so csbn is also asserted on write-only cycles.
  - Address and data lines are muxed from the granted client. Idle values are don't-care.
- Response path:
  - A registered `rd_owner` (client id) and `rd_pend` flag are captured at the read grant.
  - Next cycle, `cN_rsp_valid = rd_pend && rd_owner==N`, and `cN_rsp_rdata` is driven from `sram_rdata`.
  - There is no response backpressure; clients must sink the response in that cycle.
- A write-only cycle also clocks the macro's read register. The arbiter never asserts rsp_valid for it.

## Timing
- Reset values:
  - `rd_prio = wr_prio = 0` (client 0 favoured).
  - `rd_pend = 0`, so both rsp_valid = 0.
  - Both req_ready = 0 while `rst` is high.
  - `sram_csbn = sram_wsbn = 1`.
- Read latency: grant at edge T, `rsp_valid` high for exactly one cycle in T+1.
- Throughput: one read plus one write per cycle sustained. Back-to-back reads from one client get a response every cycle.
- Simultaneous read and write to the same address in one cycle: the response returns the pre-write memory contents, unless forwarding is enabled (see Configuration).
- Reset asserted mid-operation: `rd_pend` clears on the next edge and no response is issued for a read granted in the cycle `rst` rose. Pointers return to 0.

## Configuration
- `SRAM_ARB_FWD_EN` defined:
  - When a read and a write are granted in the same cycle with equal addresses, the granted write data is registered.
  - It is returned as the response data at T+1 in place of `sram_rdata`.
  - Adds one DW-wide register and an AW-bit comparator.
- Undefined: no bypass; same-cycle same-address reads return old data.

## Test plan
- Reset, then c0 writes `0xDEAD_BEEF_0000_0001` to addr 0x005 and reads it two cycles later -> c0_rsp_valid one cycle after the read grant, data `0xDEAD_BEEF_0000_0001`; c1_rsp_valid stays 0.
- Both clients read continuously (c0 addr 0x010, c1 addr 0x020) for 6 cycles -> grants alternate c0,c1,c0,c1,c0,c1 starting with c0; responses alternate owner one cycle later.
- c0 writes addr 0x100 while c1 reads addr 0x200 in the same cycle -> both ready=1; sram_wsbn=0 and sram_csbn=0; c1 receives mem[0x200] at T+1.
- Preload 0x300=`0x1111`; c0 writes `0x2222` to 0x300 while c1 reads 0x300 in the same cycle -> c1 gets `0x1111` without SRAM_ARB_FWD_EN and `0x2222` with it; a later read returns `0x2222` in both builds.
- Both clients write for 4 cycles, then only c1 writes -> first 4 grants alternate c0,c1,c0,c1; c1 is then granted every cycle; wr_prio ends at 0.
- Assert rst in the same cycle as a granted c1 read -> no c1_rsp_valid the following cycle; after release, a c0/c1 read contention grants c0 first.
